// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Bus payload layout toward ID: {exc, inst, pc}.
package if_fetch_unit_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD  = 65;
  localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef struct packed {
    logic        exc;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_EX,
    REDIR_ERTN,
    REDIR_BR
  } redir_e;

  // Exception beats ertn beats branch.
  function automatic redir_e redir_sel(input logic ex, input logic ertn, input logic br);
    if (ex)   return REDIR_EX;
    if (ertn) return REDIR_ERTN;
    if (br)   return REDIR_BR;
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_ibuf.sv
// Parametrised synchronous FIFO with flush; pop frees a slot for a same-cycle push.
// Used both as the instruction queue and as the pending-PC tracker.
module fetch_ibuf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: split-transaction inst fetch with outstanding tracking, redirect discard and an ID queue.
// Optional macro IF_ADEF_EN: misaligned fetch PCs produce an ADEF entry instead of a bus request.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned IBUF_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       ws_ex,
  input  logic [31:0]                ex_entry,
  input  logic                       ws_ertn,
  input  logic [31:0]                ertn_entry,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  localparam int unsigned QCNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       redir_pc_q, redir_pc_d;
  logic              redir_pend_q, redir_pend_d;
  logic [31:0]       hold_addr_q, hold_addr_d;
  logic              hold_q, hold_d;
  logic              stale_q, stale_d;
  logic [OCNT_W-1:0] disc_cnt_q, disc_cnt_d;

  redir_e            redir_kind;
  logic              redir_now;
  logic [31:0]       redir_tgt;
  logic [31:0]       issue_pc, bus_pc;
  logic              adef, adef_push;
  logic              room, new_req, accept, stale_accept, fresh_accept, rsp_valid;

  fs_to_ds_t         q_din, q_dout;
  logic [QCNT_W-1:0] q_count;
  logic              q_full, q_empty, q_push, q_pop;
  logic [31:0]       pcf_dout;
  logic [OCNT_W-1:0] out_cnt;
  logic              pcf_full, pcf_empty;

  always_comb begin
    redir_kind = redir_sel(ws_ex, ws_ertn, br_taken);
    redir_now  = (redir_kind != REDIR_NONE);
    case (redir_kind)
      REDIR_EX:   redir_tgt = ex_entry;
      REDIR_ERTN: redir_tgt = ertn_entry;
      default:    redir_tgt = br_target;
    endcase
  end

  assign issue_pc = redir_pend_q ? redir_pc_q : fetch_pc_q;

`ifdef IF_ADEF_EN
  logic adef_done_q, adef_done_d;

  assign adef      = (issue_pc[1:0] != 2'b00);
  assign bus_pc    = issue_pc;
  // ADEF entry waits until every earlier request has answered, and is emitted once per redirect.
  assign adef_push = adef & ~hold_q & pcf_empty & ~q_full & ~redir_now & ~adef_done_q & ~reset;
  assign adef_done_d = redir_now ? 1'b0 : (adef_done_q | adef_push);

  always_ff @(posedge clk) begin
    if (reset) adef_done_q <= 1'b0;
    else       adef_done_q <= adef_done_d;
  end
`else
  assign adef      = 1'b0;
  assign bus_pc    = {issue_pc[31:2], 2'b00};
  assign adef_push = 1'b0;
`endif

  // Outstanding count is the occupancy of the pending-PC FIFO.
  assign room    = (32'(q_count) + 32'(out_cnt) - 32'(disc_cnt_q)) < IBUF_DEPTH;
  assign new_req = ~hold_q & ~pcf_full & room & ~redir_now & ~adef;

  assign inst_sram_req   = ~reset & (hold_q | new_req);
  assign inst_sram_addr  = hold_q ? hold_addr_q : bus_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = INST_SIZE_WORD;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign accept       = inst_sram_req & inst_sram_addr_ok;
  assign stale_accept = accept & stale_q;
  assign fresh_accept = accept & ~stale_q;
  // Responses with nothing tracked (issued before reset) are ignored.
  assign rsp_valid    = inst_sram_data_ok & ~pcf_empty;

  assign fs_to_ds_valid = ~q_empty & ~redir_now;
  assign fs_to_ds_bus   = fs_to_ds_valid ? q_dout : '0;
  assign q_pop          = fs_to_ds_valid & ds_allowin;
  assign q_push         = adef_push | (rsp_valid & (disc_cnt_q == '0) & ~redir_now & ~q_full);

  always_comb begin
    q_din = '0;
    if (adef_push) begin
      q_din.exc = 1'b1;
      q_din.pc  = bus_pc;
    end else begin
      q_din.inst = inst_sram_rdata;
      q_din.pc   = pcf_dout;
    end
  end

  // Next-state for fetch PC, redirect latch, held request and discard counter.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    hold_d       = inst_sram_req & ~inst_sram_addr_ok;
    hold_addr_d  = hold_d ? inst_sram_addr : hold_addr_q;
    stale_d      = hold_d & (stale_q | redir_now);
    disc_cnt_d   = disc_cnt_q;
    if (redir_now) begin
      fetch_pc_d   = redir_tgt;
      redir_pc_d   = redir_tgt;
      redir_pend_d = hold_q & ~inst_sram_addr_ok;
      disc_cnt_d   = OCNT_W'(32'(out_cnt) + 32'(accept) - 32'(rsp_valid));
    end else begin
      if (fresh_accept) begin
        fetch_pc_d   = issue_pc + 32'd4;
        redir_pend_d = 1'b0;
      end
      disc_cnt_d = disc_cnt_q + OCNT_W'(stale_accept)
                 - OCNT_W'(rsp_valid && (disc_cnt_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      hold_addr_q  <= RESET_PC;
      hold_q       <= 1'b0;
      stale_q      <= 1'b0;
      disc_cnt_q   <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      hold_addr_q  <= hold_addr_d;
      hold_q       <= hold_d;
      stale_q      <= stale_d;
      disc_cnt_q   <= disc_cnt_d;
    end
  end

  fetch_ibuf #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_inst_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redir_now),
    .din_i   (q_din),
    .dout_o  (q_dout),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  fetch_ibuf #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .pop_i   (inst_sram_data_ok),
    .flush_i (1'b0),
    .din_i   (inst_sram_addr),
    .dout_o  (pcf_dout),
    .count_o (out_cnt),
    .full_o  (pcf_full),
    .empty_o (pcf_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: queue-level reference model of requests, responses and the ID queue,
// plus directed redirect scenarios pinned to literal PCs.
module tb_if_fetch_unit;

  localparam int unsigned IBUF = 2;
  localparam int unsigned MAXO = 2;
  localparam logic [31:0] RPC  = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin, br_taken, ws_ex, ws_ertn;
  logic [31:0] br_target, ex_entry, ertn_entry;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_fetch_unit #(.RESET_PC(RPC), .IBUF_DEPTH(IBUF), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .br_taken(br_taken), .br_target(br_target),
    .ws_ex(ws_ex), .ex_entry(ex_entry), .ws_ertn(ws_ertn), .ertn_entry(ertn_entry),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int unsigned p_allow, p_aok, p_dok, p_redir;
  bit          f_ex, f_ertn, f_br;
  logic [31:0] t_ex, t_ertn, t_br;

  typedef struct packed { logic [31:0] pc; logic stale; } infl_t;
  infl_t       infl[$];
  logic [31:0] exp_q[$];
  logic [31:0] bus_q[$];
  logic [31:0] delivered[$];
  logic [31:0] next_pc;
  logic [31:0] held_addr;
  bit          held_prev, held_stale, model_on;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'h1c00_0000 + 32'({$urandom_range(0, 255), 2'b00});
    if ($urandom_range(0, 7) == 0) t = t + 32'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_deliv(input int idx, input logic [31:0] exp, input string name);
    if (idx >= 0 && idx < delivered.size())
      chk(delivered[idx] === exp, name, 65'(delivered[idx]), 65'(exp));
    else
      chk(1'b0, {name, " (not delivered)"}, 65'(delivered.size()), 65'(exp));
  endtask

  task automatic drive_inputs();
    ds_allowin        = ($urandom_range(0, 99) < p_allow);
    inst_sram_addr_ok = ($urandom_range(0, 99) < p_aok);
    if (bus_q.size() > 0 && $urandom_range(0, 99) < p_dok) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(bus_q[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
    ws_ex = 1'b0; ws_ertn = 1'b0; br_taken = 1'b0;
    ex_entry = rand_tgt(); ertn_entry = rand_tgt(); br_target = rand_tgt();
    if (f_ex || f_ertn || f_br) begin
      ws_ex = f_ex; ws_ertn = f_ertn; br_taken = f_br;
      ex_entry = t_ex; ertn_entry = t_ertn; br_target = t_br;
      f_ex = 1'b0; f_ertn = 1'b0; f_br = 1'b0;
    end else if ($urandom_range(0, 99) < p_redir) begin
      ws_ex    = ($urandom_range(0, 2) == 0);
      ws_ertn  = ($urandom_range(0, 2) == 0);
      br_taken = !(ws_ex || ws_ertn) || ($urandom_range(0, 1) == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle comparison against the reference model, then advance the model by this cycle's events.
  always @(negedge clk) begin
    if (model_on) begin
      bit          redir, exp_valid, exp_req, st;
      int          nst;
      logic [31:0] tgt;
      infl_t       e;
      redir = ws_ex || ws_ertn || br_taken;
      tgt   = ws_ex ? ex_entry : (ws_ertn ? ertn_entry : br_target);
      nst   = 0;
      foreach (infl[i]) if (infl[i].stale) nst++;

      exp_valid = (exp_q.size() != 0) && !redir;
      chk(fs_to_ds_valid === exp_valid, "valid", 65'(fs_to_ds_valid), 65'(exp_valid));
      if (exp_valid)
        chk(fs_to_ds_bus === {1'b0, mem_word(exp_q[0]), exp_q[0]}, "bus",
            fs_to_ds_bus, {1'b0, mem_word(exp_q[0]), exp_q[0]});
      if (held_prev) begin
        chk(inst_sram_req === 1'b1 && inst_sram_addr === held_addr, "hold",
            {inst_sram_req, inst_sram_addr}, {1'b1, held_addr});
      end else begin
        exp_req = (infl.size() < MAXO) && (exp_q.size() + infl.size() - nst < IBUF) && !redir;
        chk(inst_sram_req === exp_req, "req", 65'(inst_sram_req), 65'(exp_req));
        if (exp_req && inst_sram_req)
          chk(inst_sram_addr === {next_pc[31:2], 2'b00}, "addr",
              65'(inst_sram_addr), 65'({next_pc[31:2], 2'b00}));
      end
      chk({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} === {1'b0, 2'b10, 4'h0, 32'h0},
          "const", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
          65'({1'b0, 2'b10, 4'h0, 32'h0}));

      if (fs_to_ds_valid && ds_allowin) delivered.push_back(fs_to_ds_bus[31:0]);
      if (exp_valid && ds_allowin) void'(exp_q.pop_front());
      if (inst_sram_data_ok && infl.size() > 0) begin
        void'(bus_q.pop_front());
        e = infl.pop_front();
        if (!e.stale && !redir) exp_q.push_back(e.pc);
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        st = held_prev && held_stale;
        bus_q.push_back(inst_sram_addr);
        infl.push_back('{pc: inst_sram_addr, stale: st});
        if (!st) next_pc = next_pc + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        next_pc = tgt;
      end
      held_stale = (inst_sram_req && !inst_sram_addr_ok) && ((held_prev && held_stale) || redir);
      held_prev  = inst_sram_req && !inst_sram_addr_ok;
      held_addr  = inst_sram_addr;
    end
  end

  initial begin
    int m;
    model_on = 1'b0;
    f_ex = 1'b0; f_ertn = 1'b0; f_br = 1'b0;
    t_ex = '0; t_ertn = '0; t_br = '0;
    reset = 1'b1;
    ds_allowin = 1'b0; br_taken = 1'b0; ws_ex = 1'b0; ws_ertn = 1'b0;
    br_target = '0; ex_entry = '0; ertn_entry = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(inst_sram_req === 1'b0 && fs_to_ds_valid === 1'b0, "reset_req_valid",
        65'({inst_sram_req, fs_to_ds_valid}), 65'(0));
    chk(inst_sram_addr === RPC && inst_sram_size === 2'b10, "reset_addr_size",
        65'({inst_sram_size, inst_sram_addr}), 65'({2'b10, RPC}));
    chk(fs_to_ds_bus === 65'h0 && inst_sram_wr === 1'b0 && inst_sram_wstrb === 4'h0 && inst_sram_wdata === 32'h0,
        "reset_zero", fs_to_ds_bus, 65'h0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    next_pc = RPC; held_prev = 1'b0; held_stale = 1'b0; held_addr = RPC;
    model_on = 1'b1;

    // Streaming from reset
    p_allow = 100; p_aok = 100; p_dok = 100; p_redir = 0;
    run(12);
    chk_deliv(0, 32'h1c00_0000, "s1_pc0");
    chk_deliv(1, 32'h1c00_0004, "s1_pc1");
    chk_deliv(2, 32'h1c00_0008, "s1_pc2");

    // ID stall then drain in order
    p_allow = 0;
    run(10);
    m = delivered.size();
    p_allow = 100;
    run(10);
    if (delivered.size() >= m + 3) begin
      chk(delivered[m+1] === delivered[m] + 32'd4, "s2_order1", 65'(delivered[m+1]), 65'(delivered[m] + 32'd4));
      chk(delivered[m+2] === delivered[m] + 32'd8, "s2_order2", 65'(delivered[m+2]), 65'(delivered[m] + 32'd8));
    end else begin
      chk(1'b0, "s2_drain_count", 65'(delivered.size() - m), 65'(3));
    end

    // Branch with two fetches in flight
    p_dok = 0;
    run(3);
    m = delivered.size();
    f_br = 1'b1; t_br = 32'h1c00_0100; p_dok = 100;
    run(12);
    chk_deliv(m, 32'h1c00_0100, "s3_br_target");

    // Exception while a request is held without addr_ok
    p_aok = 0;
    run(3);
    m = delivered.size();
    f_ex = 1'b1; t_ex = 32'h1c00_8000;
    run(1);
    run(2);
    p_aok = 100;
    run(12);
    chk_deliv(m, 32'h1c00_8000, "s4_ex_entry");

    // Redirect priority
    m = delivered.size();
    f_ex = 1'b1; f_br = 1'b1; t_ex = 32'h1c00_4000; t_br = 32'h1c00_0200; t_ertn = 32'h1c00_0300;
    run(12);
    chk_deliv(m, 32'h1c00_4000, "s5_ex_over_br");
    m = delivered.size();
    f_ertn = 1'b1; f_br = 1'b1; t_ex = 32'h1c00_0400; t_br = 32'h1c00_0500; t_ertn = 32'h1c00_6000;
    run(12);
    chk_deliv(m, 32'h1c00_6000, "s5_ertn_over_br");

    // Misaligned branch target: low address bits cleared on the bus
    m = delivered.size();
    f_br = 1'b1; t_br = 32'h1c00_0102;
    run(12);
    chk_deliv(m, 32'h1c00_0100, "s6_aligned0");
    chk_deliv(m + 1, 32'h1c00_0104, "s6_aligned1");

    // Random traffic
    p_allow = 70; p_aok = 60; p_dok = 50; p_redir = 4;
    run(3000);
    p_allow = 100; p_aok = 100; p_dok = 100; p_redir = 0;
    run(30);

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
